// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: defaults and helpers shared by the CPU character I/O blocks (inputr, outputr).
package cpu_io_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Occupancy counter width: one extra bit so a full buffer (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/outr_fifo.sv
// outr_fifo: DEPTH-entry character FIFO with wrapping pointers and an occupancy count.
// Read data is forced to zero while the FIFO is empty; there is no write-to-read bypass.
module outr_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [cnt_w(DEPTH)-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // NOTE: storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/outputr.sv
// outputr: buffers CPU OUT characters and hands them to a ready/valid device, with FGO/ovf flags.
// Optional macro OUTR_IRQ_EN adds ports ien/irq and a registered interrupt request (ien & FGO).
module outputr
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ac_in,
    output logic              FGO,
    output logic              ovf,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
`ifdef OUTR_IRQ_EN
    ,
    input  logic              ien,
    output logic              irq
`endif
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             ovf_q, ovf_d;

    // Flags come from the registered count only, so FGO never depends on this cycle's load.
    assign FGO      = (count != CNT_W'(DEPTH));
    assign tx_valid = (count != '0);
    assign push     = load & FGO;
    assign pop      = tx_valid & tx_ready;

    outr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ac_in),
        .rdata_o (tx_data),
        .count_o (count)
    );

    // A load against a full buffer is dropped and latched as overflow until reset.
    always_comb begin
        ovf_d = ovf_q;
        if (load && !FGO) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef OUTR_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ien & FGO;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_outputr.sv
// tb_outputr: directed stimulus against a queue-based model of the output buffer.
// The model is compared on every falling edge; literal expectations pin the model in each scenario.
module tb_outputr;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load = 1'b0;
    logic [DATA_W-1:0] ac_in = '0;
    logic              tx_ready = 1'b0;
    logic              ien = 1'b0;
    logic              FGO;
    logic              ovf;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
`ifdef OUTR_IRQ_EN
    logic              irq;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: buffered characters in order, sticky overflow, registered irq.
    int  mq[$];
    bit  m_ovf = 1'b0;
    bit  m_irq = 1'b0;
    bit  chk_en = 1'b0;

    outputr #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .ac_in    (ac_in),
        .FGO      (FGO),
        .ovf      (ovf),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
`ifdef OUTR_IRQ_EN
        ,
        .ien      (ien),
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, return shortly after the falling edge.
    task automatic tick(input bit r, input bit l, input logic [DATA_W-1:0] a,
                        input bit rdy, input bit ie);
        bit fgo_m;
        bit valid_m;
        rst      = r;
        load     = l;
        ac_in    = a;
        tx_ready = rdy;
        ien      = ie;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_irq = 1'b0;
        end else begin
            fgo_m   = (mq.size() != DEPTH);
            valid_m = (mq.size() != 0);
            m_irq   = ie & fgo_m;
            if (valid_m && rdy) void'(mq.pop_front());
            if (l) begin
                if (fgo_m) mq.push_back(int'(a));
                else       m_ovf = 1'b1;
            end
        end
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("FGO",      32'(FGO),      32'(mq.size() != DEPTH));
            check("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
            check("tx_data",  32'(tx_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("ovf",      32'(ovf),      32'(m_ovf));
`ifdef OUTR_IRQ_EN
            check("irq",      32'(irq),      32'(m_irq));
`endif
        end
    end

    initial begin
        // Reset state
        tick(1, 0, 8'h00, 0, 0);
        tick(1, 0, 8'h00, 0, 0);
        check("rst_fgo",   32'(FGO), 1);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_data",  32'(tx_data), 0);
        check("rst_ovf",   32'(ovf), 0);

        // Single character, no bypass, then popped
        tick(0, 1, 8'h41, 0, 0);
        check("one_valid", 32'(tx_valid), 1);
        check("one_data",  32'(tx_data), 32'h41);
        check("one_fgo",   32'(FGO), 1);
        tick(0, 0, 8'h00, 1, 0);
        check("one_pop_valid", 32'(tx_valid), 0);
        check("one_pop_data",  32'(tx_data), 0);

        // tx_ready while empty is ignored
        tick(0, 0, 8'h00, 1, 0);
        check("empty_rdy_valid", 32'(tx_valid), 0);
        check("empty_rdy_fgo",   32'(FGO), 1);

        // Fill, reject fifth, hold, drain in order
        for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h10 + i), 0, 0);
        check("full_fgo", 32'(FGO), 0);
        check("full_ovf_pre", 32'(ovf), 0);
        tick(0, 1, 8'h14, 0, 0);
        check("reject_ovf", 32'(ovf), 1);
        tick(0, 0, 8'h00, 0, 0);
        check("hold_data",  32'(tx_data), 32'h10);
        check("hold_valid", 32'(tx_valid), 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(tx_data), 32'h10 + 32'(i));
            tick(0, 0, 8'h00, 1, 0);
        end
        check("drain_empty", 32'(tx_valid), 0);
        check("ovf_sticky",  32'(ovf), 1);

        // Full with load and pop together: load rejected, count drops to 3
        tick(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h20 + i), 0, 0);
        tick(0, 1, 8'h99, 1, 0);
        check("fullpop_ovf",  32'(ovf), 1);
        check("fullpop_fgo",  32'(FGO), 1);
        check("fullpop_data", 32'(tx_data), 32'h21);
        for (int i = 1; i < 4; i++) begin
            check("fullpop_drain", 32'(tx_data), 32'h20 + 32'(i));
            tick(0, 0, 8'h00, 1, 0);
        end
        check("fullpop_empty", 32'(tx_valid), 0);

        // Count 2 with simultaneous load and pop, pointers wrap
        tick(1, 0, 8'h00, 0, 0);
        tick(0, 1, 8'h30, 0, 0);
        tick(0, 1, 8'h31, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 8'(8'h50 + i), 1, 0);
            check("wrap_fgo",   32'(FGO), 1);
            check("wrap_valid", 32'(tx_valid), 1);
        end
        check("wrap_head", 32'(tx_data), 32'h54);
        tick(0, 0, 8'h00, 1, 0);
        check("wrap_next", 32'(tx_data), 32'h55);
        tick(0, 0, 8'h00, 1, 0);
        check("wrap_empty", 32'(tx_valid), 0);
        check("wrap_ovf",   32'(ovf), 0);

        // Reset beats a load with 3 buffered and ovf set
        for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h60 + i), 0, 0);
        tick(0, 1, 8'h64, 1, 0);
        check("prerst_ovf",   32'(ovf), 1);
        check("prerst_valid", 32'(tx_valid), 1);
        tick(1, 1, 8'h77, 1, 0);
        check("rst_load_valid", 32'(tx_valid), 0);
        check("rst_load_fgo",   32'(FGO), 1);
        check("rst_load_ovf",   32'(ovf), 0);
        check("rst_load_data",  32'(tx_data), 0);
        tick(0, 0, 8'h00, 0, 0);
        check("rst_load_gone", 32'(tx_valid), 0);

`ifdef OUTR_IRQ_EN
        // irq tracks ien & FGO with one cycle of latency
        tick(0, 0, 8'h00, 0, 1);
        check("irq_idle", 32'(irq), 1);
        for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h70 + i), 0, 1);
        check("irq_fgo_fell", 32'(FGO), 0);
        check("irq_lag_hi",   32'(irq), 1);
        tick(0, 0, 8'h00, 0, 1);
        check("irq_fell", 32'(irq), 0);
        tick(0, 0, 8'h00, 1, 1);
        check("irq_fgo_rose", 32'(FGO), 1);
        check("irq_lag_lo",   32'(irq), 0);
        tick(0, 0, 8'h00, 0, 1);
        check("irq_rose", 32'(irq), 1);
        tick(0, 0, 8'h00, 0, 0);
        check("irq_ien_off", 32'(irq), 0);
`endif

        tick(0, 0, 8'h00, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
